instr_fetch: RTL and testbench

//  Upstream instruction feeder for the 16-bit bus processor. Holds a small program

---
 rtl/instr_fetch_pkg.sv | 29 ++
 rtl/instr_fetch_prog_mem.sv | 30 +++
 rtl/instr_fetch.sv | 115 +++++++++++
 tb/tb_instr_fetch.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction feeder: instruction field layout
// (common with the bus processor), fetch state encoding and memory depth.
package instr_fetch_pkg;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 13;
  localparam int X_MSB  = 12;
  localparam int X_LSB  = 10;
  localparam int Y_MSB  = 9;
  localparam int Y_LSB  = 7;

  localparam logic [2:0] OP_MVI = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic logic [2:0] op_of(input logic [15:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_prog_mem.sv
// Program store for the instruction feeder: one synchronous write port and
// two asynchronous read ports (current word and the word after it).
module instr_fetch_prog_mem
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [15:0]       rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [15:0]       rd_data_b
);

  localparam int DEPTH = depth_of(ADDR_W);

  // Contents survive reset so a loaded program can be rerun after an abort.
  logic [15:0] mem_q [DEPTH];

  always_ff @(posedge Clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];

endmodule

// File: rtl/instr_fetch.sv
// Instruction feeder for the 16-bit bus processor: walks program memory, drives
// Run/DIN, consumes Done, and halts with a sticky error on a hung instruction.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int WD_MAX = 3
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [15:0]       ld_data,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              Done,
  output logic [15:0]       DIN,
  output logic              Run,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  // state | meaning
  // IDLE  | out of reset, waiting for start
  // ISSUE | Run high, instruction word on DIN
  // EXEC  | waiting for Done; DIN carries the immediate for mvi
  // HALT  | finished, stopped or watchdog fired; may reload and restart

  localparam int WD_W = $clog2(WD_MAX + 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              err_q, err_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [15:0]       word_cur, word_nxt;
  logic              is_mvi, last_hit, ld_ok;

  assign pc_inc = pc_q + ADDR_W'(1);
  assign ld_ok  = ld_en && (state_q == ST_IDLE || state_q == ST_HALT);

  instr_fetch_prog_mem #(.ADDR_W(ADDR_W)) u_prog_mem (
    .Clock     (Clock),
    .wr_en     (ld_ok),
    .wr_addr   (ld_addr),
    .wr_data   (ld_data),
    .rd_addr_a (pc_q),
    .rd_data_a (word_cur),
    .rd_addr_b (pc_inc),
    .rd_data_b (word_nxt)
  );

  // An mvi occupies two words, so it also ends the program when its immediate sits at last_addr.
  assign is_mvi   = (op_of(word_cur) == OP_MVI);
  assign last_hit = (pc_q == last_addr) || (is_mvi && (pc_inc == last_addr));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    wd_d    = wd_q;
    Run     = 1'b0;
    DIN     = '0;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_ISSUE;
          pc_d    = '0;
          err_d   = 1'b0;
        end
      end
      ST_ISSUE: begin
        Run     = 1'b1;
        DIN     = word_cur;
        wd_d    = '0;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        DIN = is_mvi ? word_nxt : word_cur;
        if (Done) begin
          pc_d    = pc_q + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));
          state_d = (stop || last_hit) ? ST_HALT : ST_ISSUE;
        end else if (wd_q == WD_W'(WD_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  assign pc     = pc_q;
  assign err    = err_q;
  assign busy   = (state_q == ST_ISSUE) || (state_q == ST_EXEC);
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a small behavioural bus processor answers Run/DIN with
// Done, and a program-level model predicts issue trace, timing and register results.
module tb_instr_fetch;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int WD_MAX = 3;

  logic              Clock = 1'b0;
  logic              Resetn = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              ld_en = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [15:0]       ld_data = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic              Done;
  logic [15:0]       DIN;
  logic              Run;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;
  logic              err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] mem_m [DEPTH];
  logic [15:0] proc_r [8];
  logic [15:0] ref_r [8];

  // processor model state
  logic [15:0] ir;
  int          step;
  int          issue_cnt;
  logic        hang_cur;
  int          issue_base = 0;
  int          hang_at = -1;
  logic        alu_op;

  // expectations from the program model
  int          q_pc[$];
  logic [15:0] q_din[$];
  logic [15:0] q_imm[$];
  int          exp_cyc, exp_pc;
  logic        exp_err;

  instr_fetch #(.ADDR_W(ADDR_W), .WD_MAX(WD_MAX)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .start     (start),
    .stop      (stop),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .last_addr (last_addr),
    .Done      (Done),
    .DIN       (DIN),
    .Run       (Run),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .err       (err)
  );

  always #5 Clock = ~Clock;

  // Processor: mv/mvi finish in T1, add/sub in T3; a hung instruction never raises Done.
  always_comb begin
    alu_op = (ir[15:13] == 3'd2) || (ir[15:13] == 3'd3);
    Done   = !hang_cur && ((step == 1 && !alu_op) || (step == 3 && alu_op));
  end

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      step      <= 0;
      issue_cnt <= 0;
      hang_cur  <= 1'b0;
      ir        <= '0;
      for (int i = 0; i < 8; i++) proc_r[i] <= '0;
    end else if (Run) begin
      ir        <= DIN;
      step      <= 1;
      hang_cur  <= ((issue_cnt - issue_base) == hang_at);
      issue_cnt <= issue_cnt + 1;
    end else if (step != 0) begin
      if (Done) begin
        case (ir[15:13])
          3'd0: proc_r[ir[12:10]] <= proc_r[ir[9:7]];
          3'd1: proc_r[ir[12:10]] <= DIN;
          3'd2: proc_r[ir[12:10]] <= proc_r[ir[12:10]] + proc_r[ir[9:7]];
          3'd3: proc_r[ir[12:10]] <= proc_r[ir[12:10]] - proc_r[ir[9:7]];
          default: ;
        endcase
        step <= 0;
      end else if (step >= 3) begin
        step <= 0;
      end else begin
        step <= step + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic load_all();
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge Clock);
      ld_en   = 1'b1;
      ld_addr = ADDR_W'(a);
      ld_data = mem_m[a];
    end
    @(negedge Clock);
    ld_en = 1'b0;
  endtask

  // Program-level prediction: which words issue, total busy cycles, final pc, registers.
  task automatic build_expect(input int last, input int hang_idx, input int stop_pc);
    int p, n;
    logic [15:0] w, imm;
    logic [2:0] op, x, y;
    bit mvi, covers, stopped;
    q_pc.delete(); q_din.delete(); q_imm.delete();
    exp_cyc = 0;
    exp_err = 1'b0;
    for (int i = 0; i < 8; i++) ref_r[i] = proc_r[i];
    p = 0;
    n = 0;
    forever begin
      w   = mem_m[p];
      imm = mem_m[(p + 1) % DEPTH];
      op  = w[15:13];
      x   = w[12:10];
      y   = w[9:7];
      mvi = (op == 3'd1);
      q_pc.push_back(p);
      q_din.push_back(w);
      q_imm.push_back(imm);
      if (n == hang_idx) begin
        exp_cyc += 1 + WD_MAX;
        exp_err = 1'b1;
        break;
      end
      exp_cyc += (op == 3'd2 || op == 3'd3) ? 4 : 2;
      case (op)
        3'd0: ref_r[x] = ref_r[y];
        3'd1: ref_r[x] = imm;
        3'd2: ref_r[x] = ref_r[x] + ref_r[y];
        3'd3: ref_r[x] = ref_r[x] - ref_r[y];
        default: ;
      endcase
      covers  = (p == last) || (mvi && ((p + 1) % DEPTH) == last);
      stopped = (p == stop_pc);
      p = (p + (mvi ? 2 : 1)) % DEPTH;
      n++;
      if (covers || stopped || n >= 64) break;
    end
    exp_pc = p;
  endtask

  task automatic run_prog(input int last, input int hang_idx, input int stop_pc,
                          input bit ld_w, input int ld_a, input logic [15:0] ld_d,
                          input bit noise);
    int cyc, idx;
    bit prev_mvi;
    logic [15:0] exp_imm, w;
    if (ld_w) mem_m[ld_a] = ld_d;
    build_expect(last, hang_idx, stop_pc);
    @(negedge Clock);
    hang_at    = hang_idx;
    issue_base = issue_cnt;
    start      = 1'b1;
    last_addr  = ADDR_W'(last);
    if (ld_w) begin
      ld_en   = 1'b1;
      ld_addr = ADDR_W'(ld_a);
      ld_data = ld_d;
    end
    @(negedge Clock);
    start = 1'b0;
    ld_en = 1'b0;
    check("err_clr", err, 0);
    cyc = 0;
    idx = 0;
    prev_mvi = 1'b0;
    exp_imm = '0;
    while (!halted && cyc < 300) begin
      cyc++;
      if (Run) begin
        if (idx < q_pc.size()) begin
          w = q_din[idx];
          check("issue_pc", pc, q_pc[idx]);
          check("issue_din", DIN, w);
          prev_mvi = (w[15:13] == 3'd1);
          exp_imm  = q_imm[idx];
        end else begin
          check("extra_issue", idx, q_pc.size());
        end
        idx++;
      end else if (prev_mvi) begin
        check("imm_din", DIN, exp_imm);
        prev_mvi = 1'b0;
      end
      if (stop_pc >= 0 && busy && !Run && pc == ADDR_W'(stop_pc)) stop = 1'b1;
      if (noise) begin
        start = ($urandom_range(0, 7) == 0);
        ld_en = ($urandom_range(0, 3) == 0);
        ld_addr = ADDR_W'($urandom);
        ld_data = 16'($urandom);
      end
      @(negedge Clock);
    end
    start = 1'b0;
    stop  = 1'b0;
    ld_en = 1'b0;
    check("cycles", cyc, exp_cyc);
    check("n_issue", idx, q_pc.size());
    check("final_pc", pc, exp_pc);
    check("err", err, exp_err);
    check("halted", halted, 1);
    check("busy", busy, 0);
    for (int i = 0; i < 8; i++) check($sformatf("reg_r%0d", i), proc_r[i], ref_r[i]);
  endtask

  initial begin
    int k, len, last, hng, stp;
    logic [15:0] w;

    #1 Resetn = 1'b0;
    #3;
    check("rst_run", Run, 0);
    check("rst_din", DIN, 0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_err", err, 0);
    @(negedge Clock);
    Resetn = 1'b1;

    for (int a = 0; a < DEPTH; a++) mem_m[a] = 16'($urandom);

    // mvi R0,5 ; mv R1,R0
    mem_m[0] = 16'h2000; mem_m[1] = 16'h0005; mem_m[2] = 16'h0400;
    load_all();
    run_prog(2, -1, -1, 1'b0, 0, 16'h0, 1'b0);
    check("t1_r0", proc_r[0], 16'h0005);
    check("t1_r1", proc_r[1], 16'h0005);

    // R0=2, R1=3, add R0,R1
    mem_m[0] = 16'h2000; mem_m[1] = 16'h0002; mem_m[2] = 16'h2400;
    mem_m[3] = 16'h0003; mem_m[4] = 16'h4080;
    load_all();
    run_prog(4, -1, -1, 1'b0, 0, 16'h0, 1'b0);
    check("t2_r0", proc_r[0], 16'h0005);

    // hung first instruction -> watchdog
    mem_m[0] = 16'h0000;
    load_all();
    run_prog(0, 0, -1, 1'b0, 0, 16'h0, 1'b0);
    check("t3_err", err, 1);

    // mvi at the top address takes its immediate from word 0
    mem_m[0] = 16'h00AA;
    for (int a = 1; a < DEPTH - 1; a++) mem_m[a] = 16'h0000;
    mem_m[DEPTH-1] = 16'h2800;
    load_all();
    run_prog(DEPTH - 1, -1, -1, 1'b0, 0, 16'h0, 1'b0);
    check("t4_r2", proc_r[2], 16'h00AA);
    check("t4_pc", pc, 1);

    // stop during EXEC of word 1 of a 4-word program
    mem_m[0] = 16'h4080; mem_m[1] = 16'h4080; mem_m[2] = 16'h0400; mem_m[3] = 16'h6080;
    load_all();
    run_prog(3, -1, 1, 1'b0, 0, 16'h0, 1'b0);
    check("t5_pc", pc, 2);

    // reset during EXEC; a load attempted while busy must not land
    mem_m[0] = 16'h0980; mem_m[1] = 16'h4080; mem_m[2] = 16'h0400;
    load_all();
    @(negedge Clock);
    hang_at    = -1;
    issue_base = issue_cnt;
    start      = 1'b1;
    last_addr  = 5'd2;
    @(negedge Clock);
    start = 1'b0;
    k = 0;
    while (!(Run && pc == 5'd1) && k < 20) begin
      @(negedge Clock);
      k++;
    end
    check("t6_reach", (k < 20), 1);
    @(negedge Clock);
    ld_en   = 1'b1;
    ld_addr = 5'd2;
    ld_data = 16'hFFFF;
    @(negedge Clock);
    ld_en = 1'b0;
    check("t6_busy", busy, 1);
    #2 Resetn = 1'b0;
    #1;
    check("t6_run", Run, 0);
    check("t6_din", DIN, 0);
    check("t6_pc", pc, 0);
    check("t6_busy_rst", busy, 0);
    check("t6_halted", halted, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    // start and load in the same IDLE cycle: the new word 0 is what issues
    run_prog(2, -1, -1, 1'b1, 0, 16'h0D00, 1'b0);

    // randomized programs with hangs, stops and ignored start/load noise
    for (int it = 0; it < 25; it++) begin
      len = $urandom_range(1, 10);
      for (int a = 0; a < DEPTH; a++) begin
        w = 16'($urandom);
        if (a < len) w[15:13] = 3'($urandom_range(0, 3));
        mem_m[a] = w;
      end
      load_all();
      last = len - 1;
      hng  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      stp  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      w = 16'($urandom);
      w[15:13] = 3'($urandom_range(0, 3));
      run_prog(last, hng, stp, ($urandom_range(0, 3) == 0), $urandom_range(0, len - 1), w, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
